// File: rtl/bus_capture_sync.sv
// rtl/bus_capture_sync.sv - captures a quasi-static bus on synchronized enable events behind a valid/ready holding register
module bus_capture_sync #(
    parameter int BUS_WIDTH   = 8,
    parameter int TOGGLE_MODE = 0,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN_SYNC,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 DATA_READY,
    input  logic                 OVERRUN_CLR,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 DATA_VALID,
    output logic                 OVERRUN,
    output logic [CNT_WIDTH-1:0] ACCEPT_CNT
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic en_q;
    logic primed;
    logic edge_seen;
    logic event_det;
    logic capture;
    logic drop;

    // Event detection; suppressed until en_q holds a real previous sample,
    // so a level already high at reset release is never mistaken for an edge.
    always_comb begin
        edge_seen = 1'b0;
        if (TOGGLE_MODE != 0) begin
            edge_seen = EN_SYNC ^ en_q;
        end else begin
            edge_seen = EN_SYNC & ~en_q;
        end
        event_det = primed & edge_seen;
    end

    // Holding register next-state: decides capture, drop or drain for this edge.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        drop    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (event_det) begin
                    capture = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (DATA_READY) begin
                    if (event_det) begin
                        capture = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (event_det) begin
                    drop = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State, captured word, counter and sticky overrun; reset beats everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= EMPTY;
            en_q       <= 1'b0;
            primed     <= 1'b0;
            SYNC_BUS   <= '0;
            OVERRUN    <= 1'b0;
            ACCEPT_CNT <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= EN_SYNC;
            primed  <= 1'b1;
            if (capture) begin
                SYNC_BUS   <= UNSYNC_BUS;
                ACCEPT_CNT <= ACCEPT_CNT + CNT_WIDTH'(1);
            end
            if (drop) begin
                OVERRUN <= 1'b1;
            end else if (OVERRUN_CLR) begin
                OVERRUN <= 1'b0;
            end
        end
    end

    assign DATA_VALID = (state_q == FULL);

endmodule

// File: doc/bus_capture_sync.md
# bus_capture_sync

Destination-domain consumer of a bit synchronizer's output. It takes the already-synchronized enable level, detects enable events, and captures the quasi-static unsynchronized data bus at a safe point. It presents the captured word on a valid/ready handshake, flags overruns, and counts accepted words. It sits between the enable bit synchronizer and the destination-domain logic, such as the register file or TX FIFO write side.

## Interface
- BUS_WIDTH, 8: width of the captured data bus.
- TOGGLE_MODE, 0: 0 = a rising edge of EN_SYNC is an event; 1 = any transition of EN_SYNC is an event (toggle protocol).
- CNT_WIDTH, 8: width of the accepted-word counter.

Ports:
- CLK  in  1  destination clock; all logic on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- EN_SYNC  in  1  enable level, already synchronized into CLK by the upstream bit synchronizer.
- UNSYNC_BUS  in  BUS_WIDTH  source-domain data; the source holds it stable around each enable event.
- DATA_READY  in  1  the consumer accepts SYNC_BUS in cycles where DATA_VALID=1.
- OVERRUN_CLR  in  1  clears OVERRUN.
- SYNC_BUS  out  BUS_WIDTH  captured word; registered.
- DATA_VALID  out  1  SYNC_BUS holds an unconsumed word.
- OVERRUN  out  1  sticky; an event arrived while the holding register was full.
- ACCEPT_CNT  out  CNT_WIDTH  count of captured words; wraps modulo 2^CNT_WIDTH.

## Operation
- Internal registers:
  - en_q: previous EN_SYNC.
  - primed flag.
  - holding register with a two-state FSM: EMPTY (DATA_VALID=0) and FULL (DATA_VALID=1).
- **Priming.** In the first cycle after RST deasserts, primed=0. In that cycle en_q loads EN_SYNC and no event is generated, so an EN_SYNC level already high at reset release is never an event. primed=1 from then on.
- **Event.** Requires primed=1.
  - TOGGLE_MODE=0: EN_SYNC & ~en_q.
  - TOGGLE_MODE=1: EN_SYNC ^ en_q.
- **Space.** space = ~DATA_VALID | DATA_READY.
- **FSM.**
  - EMPTY, event: SYNC_BUS <= UNSYNC_BUS, go FULL, ACCEPT_CNT += 1.
  - EMPTY, no event: hold.
  - FULL, DATA_READY & ~event: go EMPTY; SYNC_BUS keeps its last value.
  - FULL, DATA_READY & event: capture the new word, stay FULL, ACCEPT_CNT += 1 (back-to-back).
  - FULL, ~DATA_READY & event: the new word is dropped; SYNC_BUS, DATA_VALID and ACCEPT_CNT are unchanged; OVERRUN <= 1.
  - FULL, ~DATA_READY & ~event: hold.
- **OVERRUN.**
  - Set on a dropped event.
  - Cleared by OVERRUN_CLR.
  - If set and clear occur in the same cycle, set wins.
- **Data path.** SYNC_BUS changes only on a capture; it is never combinational from UNSYNC_BUS. DATA_READY while EMPTY is ignored.
- **Reset.** RST has priority over all other inputs, including mid-transaction.
  - SYNC_BUS=0, DATA_VALID=0, OVERRUN=0, ACCEPT_CNT=0.
  - en_q=0, primed=0, FSM=EMPTY.
  - Any held word is discarded.

## Timing
- Capture latency: UNSYNC_BUS is sampled at the edge ending the cycle in which EN_SYNC first shows the event. DATA_VALID and SYNC_BUS are visible one cycle after the event cycle.
- Source contract: UNSYNC_BUS stable from at least NUM_STAGES+1 destination cycles before the raw enable edge until one cycle after the sampling edge. The upstream bit synchronizer depth covers the setup side.
- Handshake:
  - A word transfers on any edge with DATA_VALID & DATA_READY.
  - DATA_VALID deasserts on the following edge unless a new word is captured on that same edge.
- Throughput: one word per cycle is possible in TOGGLE_MODE=1 with DATA_READY held at 1. TOGGLE_MODE=0 is limited to one word per two cycles by the level protocol.
- ACCEPT_CNT, OVERRUN and DATA_VALID all update on the same edge as the causing event.
- All outputs are registered.

## Test plan
- **Reset and priming:** hold EN_SYNC=1 through RST, release RST -> no capture, DATA_VALID=0, ACCEPT_CNT=0. Then EN_SYNC 1->0->1 (mode 0) with UNSYNC_BUS=0xA5 -> SYNC_BUS=0xA5, DATA_VALID=1 one cycle later, ACCEPT_CNT=1.
- **Overrun:** DATA_READY=0, two rising events with 0x11 then 0x22 -> SYNC_BUS stays 0x11, OVERRUN=1, ACCEPT_CNT=1. Pulse OVERRUN_CLR -> OVERRUN=0. Assert OVERRUN_CLR in the same cycle as a new dropped event -> OVERRUN stays 1.
- **Back-to-back, TOGGLE_MODE=1:** DATA_READY=1, EN_SYNC toggles every cycle with bus 0x01, 0x02, 0x03 -> DATA_VALID continuously 1, SYNC_BUS steps 0x01, 0x02, 0x03 on consecutive cycles, no OVERRUN, ACCEPT_CNT=3.
- **Mode 0 falling edge ignored:** EN_SYNC 1->0 -> no capture, ACCEPT_CNT unchanged.
- **Counter wrap:** CNT_WIDTH=8, 256 accepted events -> ACCEPT_CNT returns to 0; the 257th event gives 1.
- **Reset mid-operation:** with DATA_VALID=1 and OVERRUN=1, assert RST for one cycle -> next edge: all outputs 0, and the held word is not delivered afterwards.
